// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider state encoding, default width and the
// quotient returned for a divide by zero.
package alu_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Sliced down to the instance width; supports WIDTH up to 64.
    localparam logic [63:0] DBZ_QUOT_ALL = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the dividend MSB, trial-subtract
// the divisor and keep the difference only when no borrow occurs.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   i_r,
    input  logic             i_q_msb,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH:0]   o_r_next,
    output logic             o_q_bit,
    output logic             o_no_borrow
);

    logic [WIDTH:0]   w_rs;
    logic [WIDTH+1:0] w_sum;
    logic             w_unused_r_msb;

    // R is always below D, so its top bit never reaches the shifted value.
    assign w_unused_r_msb = i_r[WIDTH];

    assign w_rs  = {i_r[WIDTH-1:0], i_q_msb};
    assign w_sum = {1'b0, w_rs} + {1'b0, ~{1'b0, i_d}} + {{(WIDTH+1){1'b0}}, 1'b1};

    assign o_no_borrow = w_sum[WIDTH+1];
    assign o_q_bit     = w_sum[WIDTH+1];
    assign o_r_next    = w_sum[WIDTH+1] ? w_sum[WIDTH:0] : w_rs;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider with start/done handshake.
// IDLE: waiting for start | RUN: one quotient bit per clock | DONE: one-cycle result pulse
module seq_divider
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH,
    parameter int unsigned CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam logic [WIDTH-1:0] DBZ_QUOT = DBZ_QUOT_ALL[WIDTH-1:0];
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_t       r_state;
    div_state_t       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH:0]   r_r;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dbz;

    logic             w_accept;
    logic             w_div_zero;
    logic             w_last;
    logic [WIDTH:0]   w_r_next;
    logic             w_q_bit;
    logic             w_unused_no_borrow;
    logic [WIDTH-1:0] w_q_next;

    assign w_div_zero = (divisor == '0);
    assign w_accept   = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last     = (r_state == RUN) && (r_cnt == LAST_CNT);
    assign w_q_next   = {r_q[WIDTH-2:0], w_q_bit};

    div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .i_r        (r_r),
        .i_q_msb    (r_q[WIDTH-1]),
        .i_d        (r_d),
        .o_r_next   (w_r_next),
        .o_q_bit    (w_q_bit),
        .o_no_borrow(w_unused_no_borrow)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_next = w_div_zero ? DONE : RUN;
                end else begin
                    w_state_next = IDLE;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Published results move only at completion (or immediately for divide by zero).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_d         <= '0;
            r_q         <= '0;
            r_r         <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else if (w_accept) begin
            r_d   <= divisor;
            r_q   <= dividend;
            r_r   <= '0;
            r_cnt <= '0;
            if (w_div_zero) begin
                r_quotient  <= DBZ_QUOT;
                r_remainder <= dividend;
                r_dbz       <= 1'b1;
            end else begin
                r_dbz <= 1'b0;
            end
        end else if (r_state == RUN) begin
            r_r   <= w_r_next;
            r_q   <= w_q_next;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_quotient  <= w_q_next;
                r_remainder <= w_r_next[WIDTH-1:0];
            end
        end
    end

    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: expected results queued at start,
// compared when done pulses.
module tb_seq_divider;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  dividend;
    logic [W-1:0]  divisor;
    logic          busy;
    logic          done;
    logic [W-1:0]  quotient;
    logic [W-1:0]  remainder;
    logic          div_by_zero;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    seq_divider #(.WIDTH(W), .CNT_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [63:0] recon;
        if (rst === 1'b0 && done === 1'b1) begin
            if (sb.size() == 0) begin
                check_val("sb_unexpected_done", 64'(1), 64'(0));
            end else begin
                e = sb.pop_front();
                check_val("quotient", 64'(quotient), 64'(e.q));
                check_val("remainder", 64'(remainder), 64'(e.r));
                check_val("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
                check_val("busy_in_done", 64'(busy), 64'(0));
                if (!e.dbz) begin
                    recon = 64'(quotient) * 64'(e.b) + 64'(remainder);
                    check_val("invariant", recon, 64'(e.a));
                    check_val("rem_lt_div", 64'(remainder < e.b), 64'(1));
                end
            end
        end
    end

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.a = a;
        e.b = b;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
        end else begin
            e.q   = a / b;
            e.r   = a % b;
            e.dbz = 1'b0;
        end
        sb.push_back(e);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges after the current point until done is seen.
    task automatic wait_done(input string tag, input int exp_lat, output int nbusy);
        int n;
        n     = 0;
        nbusy = 0;
        while (done !== 1'b1 && n < 200) begin
            if (busy === 1'b1) nbusy++;
            @(posedge clk);
            #1;
            n++;
        end
        check_val(tag, 64'(n), 64'(exp_lat));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int nb;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("rst_busy", 64'(busy), 64'(0));
        check_val("rst_done", 64'(done), 64'(0));
        check_val("rst_quot", 64'(quotient), 64'(0));
        check_val("rst_rem", 64'(remainder), 64'(0));
        check_val("rst_dbz", 64'(div_by_zero), 64'(0));

        start_op(100, 7);
        check_val("busy_after_start", 64'(busy), 64'(1));
        wait_done("lat_100_7", 32, nb);
        check_val("busy_cycles_100_7", 64'(nb), 64'(32));
        @(posedge clk);
        #1;
        check_val("done_one_cycle", 64'(done), 64'(0));
        check_val("busy_idle", 64'(busy), 64'(0));

        start_op(32'hFFFF_FFFF, 1);
        wait_done("lat_max_div1", 32, nb);

        start_op(3, 10);
        wait_done("lat_3_10", 32, nb);
        start_op(50, 6);
        check_val("hold_quot_in_run", 64'(quotient), 64'(0));
        check_val("hold_rem_in_run", 64'(remainder), 64'(3));
        wait_done("lat_b2b_50_6", 32, nb);

        start_op(32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("lat_wide_trial", 32, nb);

        start_op(5, 0);
        check_val("dbz_done_now", 64'(done), 64'(1));
        wait_done("lat_dbz", 0, nb);
        check_val("dbz_busy_cycles", 64'(nb), 64'(0));
        check_val("dbz_busy", 64'(busy), 64'(0));
        start_op(3, 10);
        check_val("dbz_flag_cleared", 64'(div_by_zero), 64'(0));
        check_val("dbz_quot_held", 64'(quotient), 64'(32'hFFFF_FFFF));
        wait_done("lat_after_dbz", 32, nb);

        // A start five edges into RUN must not disturb the running operation.
        start_op(100, 7);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        start    = 1'b1;
        dividend = 9;
        divisor  = 3;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("lat_ignore_start", 27, nb);

        start_op(100, 7);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        check_val("midrun_rst_busy", 64'(busy), 64'(0));
        check_val("midrun_rst_done", 64'(done), 64'(0));
        check_val("midrun_rst_quot", 64'(quotient), 64'(0));
        check_val("midrun_rst_rem", 64'(remainder), 64'(0));
        check_val("midrun_rst_dbz", 64'(div_by_zero), 64'(0));
        @(posedge clk);
        #1;
        check_val("idle_after_rst_busy", 64'(busy), 64'(0));
        check_val("idle_after_rst_done", 64'(done), 64'(0));

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = (i % 2 == 0) ? $urandom : $urandom_range(1, 1000);
            if (rb == '0) rb = 1;
            start_op(ra, rb);
            wait_done("lat_rand", 32, nb);
        end

        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_val("sb_drained", 64'(sb.size()), 64'(0));
        check_val("final_idle", 64'(busy), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
